// File: rtl/seg7_capture_decoder_if.sv
// ============================================================================
// seg7_capture_decoder_if : display-bus sampling and decoded-frame outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface seg7_capture_decoder_if #(
   parameter int NDIG = 4
);
   logic [7:0]          sev_seg_i;
   logic [NDIG-1:0]     an_i;
   logic [4*NDIG-1:0]   bcd_o;
   logic [NDIG-1:0]     dp_o;
   logic [NDIG-1:0]     err_o;
   logic                frame_valid_o;
   logic                timeout_o;

   modport master (
      output sev_seg_i, an_i,
      input  bcd_o, dp_o, err_o, frame_valid_o, timeout_o
   );

   modport slave (
      input  sev_seg_i, an_i,
      output bcd_o, dp_o, err_o, frame_valid_o, timeout_o
   );
endinterface

`default_nettype wire

// File: rtl/seg7_capture_decoder.sv
// ============================================================================
// seg7_capture_decoder : samples a multiplexed 7-seg bus, debounces each
// pattern, decodes digits and publishes complete NDIG-digit frames.
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_capture_decoder #(
   parameter int NDIG        = 4,
   parameter int STABLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  wire logic             clk_i,
   input  wire logic             rst_n_i,
   seg7_capture_decoder_if.slave bus
);

   localparam int c_SW  = 8 + NDIG;
   localparam int c_STW = $clog2(STABLE_CYC + 2);
   localparam int c_TW  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_STW-1:0] c_STAB_ACC = c_STW'(STABLE_CYC);
   localparam logic [c_STW-1:0] c_STAB_MAX = c_STW'(STABLE_CYC + 1);
   localparam logic [c_TW-1:0]  c_TMO_END  = c_TW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_PUBLISH = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [c_SW-1:0]     r_sync1;
   logic [c_SW-1:0]     r_sync2;
   logic [c_SW-1:0]     r_prev;
   logic [c_STW-1:0]    r_stab;
   logic [c_TW-1:0]     r_tmo;

   logic [NDIG-1:0]     r_flags;
   logic [NDIG-1:0]     w_flags_nxt;
   logic [4*NDIG-1:0]   r_sh_bcd;
   logic [NDIG-1:0]     r_sh_dp;
   logic [NDIG-1:0]     r_sh_err;
   logic [4*NDIG-1:0]   w_sh_bcd_nxt;
   logic [NDIG-1:0]     w_sh_dp_nxt;
   logic [NDIG-1:0]     w_sh_err_nxt;

   logic [4*NDIG-1:0]   r_bcd;
   logic [NDIG-1:0]     r_dp;
   logic [NDIG-1:0]     r_err;
   logic                r_frame_valid;
   logic                r_timeout;

   logic                w_accept;
   logic                w_valid_acc;
   logic [7:0]          w_seg;
   logic [NDIG-1:0]     w_an_low;
   logic [NDIG-1:0]     w_acc_vec;
   logic [4:0]          w_dec;
   logic                w_tmo_clr;
   logic                w_publish;
   logic                w_timeout;

   // Returns {err, code}; unknown patterns decode to F with err set.
   function automatic logic [4:0] f_decode(input logic [6:0] p);
      logic [4:0] v;
      case (p)
         7'b0000001: v = {1'b0, 4'h0};
         7'b1001111: v = {1'b0, 4'h1};
         7'b0010010: v = {1'b0, 4'h2};
         7'b0000110: v = {1'b0, 4'h3};
         7'b1001100: v = {1'b0, 4'h4};
         7'b0100100: v = {1'b0, 4'h5};
         7'b1100000: v = {1'b0, 4'h6};
         7'b0001111: v = {1'b0, 4'h7};
         7'b0000000: v = {1'b0, 4'h8};
         7'b0001100: v = {1'b0, 4'h9};
         7'b0001000: v = {1'b0, 4'hA};
         7'b1100010: v = {1'b0, 4'hB};
         7'b1110010: v = {1'b0, 4'hC};
         7'b1000010: v = {1'b0, 4'hD};
         7'b0110000: v = {1'b0, 4'hE};
         7'b1111111: v = {1'b0, 4'hF};
         default:    v = {1'b1, 4'hF};
      endcase
      return v;
   endfunction

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
         r_stab  <= '0;
      end else begin
         r_sync1 <= {bus.sev_seg_i, bus.an_i};
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         if (r_sync2 != r_prev) begin
            r_stab <= c_STW'(1);
         end else if (r_stab != c_STAB_MAX) begin
            r_stab <= r_stab + c_STW'(1);
         end
      end
   end

   // r_prev holds the value that the counter has been qualifying, so it is
   // the pattern being accepted even if r_sync2 moved on this very edge.
   assign w_accept    = (r_stab == c_STAB_ACC);
   assign w_seg       = r_prev[c_SW-1:NDIG];
   assign w_an_low    = ~r_prev[NDIG-1:0];
   assign w_valid_acc = w_accept && $onehot(w_an_low);
   assign w_acc_vec   = w_valid_acc ? w_an_low : '0;
   assign w_dec       = f_decode(w_seg[7:1]);

   always_comb begin
      w_sh_bcd_nxt = r_sh_bcd;
      w_sh_dp_nxt  = r_sh_dp;
      w_sh_err_nxt = r_sh_err;
      for (int k = 0; k < NDIG; k++) begin
         if (w_acc_vec[k]) begin
            w_sh_bcd_nxt[4*k +: 4] = w_dec[3:0];
            w_sh_dp_nxt[k]         = ~w_seg[0];
            w_sh_err_nxt[k]        = w_dec[4];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_flags_nxt = r_flags | w_acc_vec;
      w_tmo_clr   = 1'b0;
      w_publish   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_valid_acc) begin
               w_state_nxt = S_COLLECT;
               w_tmo_clr   = 1'b1;
            end
         end
         S_COLLECT: begin
            // Completion has priority over an expiring timeout.
            if (&w_flags_nxt) begin
               w_state_nxt = S_PUBLISH;
               w_publish   = 1'b1;
            end else if (r_tmo == c_TMO_END) begin
               w_state_nxt = S_IDLE;
               w_timeout   = 1'b1;
               w_flags_nxt = '0;
            end
         end
         S_PUBLISH: begin
            w_flags_nxt = w_acc_vec;
            if (w_valid_acc) begin
               w_state_nxt = S_COLLECT;
               w_tmo_clr   = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_flags_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= S_IDLE;
         r_flags  <= '0;
         r_sh_bcd <= '0;
         r_sh_dp  <= '0;
         r_sh_err <= '0;
         r_tmo    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_flags  <= w_flags_nxt;
         r_sh_bcd <= w_sh_bcd_nxt;
         r_sh_dp  <= w_sh_dp_nxt;
         r_sh_err <= w_sh_err_nxt;
         if (w_tmo_clr) begin
            r_tmo <= '0;
         end else if ((r_state == S_COLLECT) && (r_tmo != c_TMO_END)) begin
            r_tmo <= r_tmo + c_TW'(1);
         end
      end
   end

   // Outputs load on the edge entering PUBLISH so the pulse and the new
   // frame are visible together during the PUBLISH cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_bcd         <= '0;
         r_dp          <= '0;
         r_err         <= '0;
         r_frame_valid <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         if (w_publish) begin
            r_bcd <= w_sh_bcd_nxt;
            r_dp  <= w_sh_dp_nxt;
            r_err <= w_sh_err_nxt;
         end
         r_frame_valid <= w_publish;
         r_timeout     <= w_timeout;
      end
   end

   assign bus.bcd_o         = r_bcd;
   assign bus.dp_o          = r_dp;
   assign bus.err_o         = r_err;
   assign bus.frame_valid_o = r_frame_valid;
   assign bus.timeout_o     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_seg7_capture_decoder.sv
// ============================================================================
// tb_seg7_capture_decoder : directed and randomized scans against a
// frame-level reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_seg7_capture_decoder;

   localparam int NDIG   = 4;
   localparam int STABLE = 4;
   localparam int TMO    = 100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg7_capture_decoder_if #(.NDIG(NDIG)) bus ();

   seg7_capture_decoder #(
      .NDIG        (NDIG),
      .STABLE_CYC  (STABLE),
      .TIMEOUT_CYC (TMO)
   ) u_dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   logic [6:0] pat_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b1100000, 7'b0001111,
                                7'b0000000, 7'b0001100, 7'b0001000, 7'b1100010,
                                7'b1110010, 7'b1000010, 7'b0110000, 7'b1111111};
   logic [3:0] bad_an [6] = '{4'b0000, 4'b1111, 4'b0011, 4'b1010, 4'b0101, 4'b1100};

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_to    = 0;
   int to_cyc  = 0;
   int step_cyc = 0;
   logic [23:0] obs_q [$];
   logic [23:0] exp_q [$];

   // Reference model state: one entry per digit plus the last-run tracker.
   logic [11:0] m_last;
   int          m_run;
   bit          m_acc;
   bit          m_have [NDIG];
   logic [3:0]  m_bcd  [NDIG];
   bit          m_dp   [NDIG];
   bit          m_err  [NDIG];
   logic [23:0] m_last_frame = '0;
   bit          g_first;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.frame_valid_o) obs_q.push_back({bus.err_o, bus.dp_o, bus.bcd_o});
         if (bus.timeout_o) begin
            n_to++;
            to_cyc = cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic logic [4:0] m_decode(input logic [6:0] p);
      for (int i = 0; i < 16; i++) if (pat_tab[i] == p) return {1'b0, 4'(i)};
      return {1'b1, 4'hF};
   endfunction

   function automatic logic [7:0] sb(input int code, input bit dp_lit);
      return {pat_tab[code], ~dp_lit};
   endfunction

   function automatic logic [3:0] an_of(input int d);
      logic [3:0] a;
      a = 4'b0001 << d;
      return ~a;
   endfunction

   function automatic logic [7:0] rand_seg();
      if ($urandom_range(3, 0) != 0) return {pat_tab[$urandom_range(15, 0)], 1'($urandom)};
      return 8'($urandom);
   endfunction

   task automatic m_reset();
      m_last = '0;
      m_run  = 0;
      m_acc  = 1'b0;
      for (int i = 0; i < NDIG; i++) m_have[i] = 1'b0;
   endtask

   task automatic m_accept(input logic [11:0] v);
      int k;
      int nlow;
      bit all;
      logic [4:0] dc;
      logic [23:0] f;
      nlow = 0;
      k = 0;
      for (int i = 0; i < NDIG; i++) if (!v[i]) begin nlow++; k = i; end
      if (nlow != 1) return;
      dc = m_decode(v[11:5]);
      m_bcd[k]  = dc[3:0];
      m_err[k]  = dc[4];
      m_dp[k]   = ~v[4];
      m_have[k] = 1'b1;
      all = 1'b1;
      for (int i = 0; i < NDIG; i++) if (!m_have[i]) all = 1'b0;
      if (all) begin
         f = '0;
         for (int i = 0; i < NDIG; i++) begin
            f[4*i +: 4] = m_bcd[i];
            f[16 + i]   = m_dp[i];
            f[20 + i]   = m_err[i];
            m_have[i]   = 1'b0;
         end
         exp_q.push_back(f);
         m_last_frame = f;
      end
   endtask

   // A pattern counts once it has been held STABLE clocks without change.
   task automatic m_advance(input logic [11:0] v, input int h);
      if (v != m_last) begin
         m_last = v;
         m_run  = 0;
         m_acc  = 1'b0;
      end
      m_run += h;
      if (!m_acc && m_run >= STABLE) begin
         m_acc = 1'b1;
         m_accept(v);
      end
   endtask

   task automatic step(input logic [7:0] s, input logic [3:0] a, input int h);
      @(posedge clk);
      #1;
      step_cyc = cyc;
      bus.sev_seg_i = s;
      bus.an_i      = a;
      m_advance({s, a}, h);
      repeat (h - 1) @(posedge clk);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
      m_advance(m_last, n);
   endtask

   task automatic rstep(input logic [7:0] s, input logic [3:0] a, input int h);
      logic [7:0] s2;
      s2 = s;
      if (g_first && ({s2, a} == m_last)) s2[0] = ~s2[0];
      g_first = 1'b0;
      step(s2, a, h);
   endtask

   task automatic chk_frames(input string tag);
      logic [23:0] o;
      logic [23:0] e;
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_frame"}, o, e);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_bcd"}, bus.bcd_o, 0);
      chk({tag, "_dp"},  bus.dp_o, 0);
      chk({tag, "_err"}, bus.err_o, 0);
      chk({tag, "_fv"},  bus.frame_valid_o, 0);
      chk({tag, "_to"},  bus.timeout_o, 0);
   endtask

   logic [7:0] s;
   logic [3:0] a;
   int         h;
   int         t0;
   int         order [4];
   int         tmp;
   int         j;

   initial begin
      bus.sev_seg_i = 8'hFF;
      bus.an_i      = 4'hF;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      // Plain scan 0..3
      for (int d = 0; d < 4; d++) step(sb(d, 1'b0), an_of(d), 10);
      settle(4);
      chk_frames("scan0123");
      chk("scan0123_bcd", bus.bcd_o, 16'h3210);
      chk("scan0123_err", bus.err_o, 4'h0);

      // All-lit pattern and an unknown pattern
      step(sb(5, 1'b0), an_of(0), 10);
      step(8'b1111110_1, an_of(1), 10);
      step(8'h00, an_of(2), 10);
      step(sb(9, 1'b0), an_of(3), 10);
      settle(4);
      chk_frames("alllit_bad");
      chk("digit2_eight", bus.bcd_o[11:8], 4'h8);
      chk("digit2_dp", bus.dp_o[2], 1'b1);
      chk("digit1_err", bus.err_o[1], 1'b1);
      chk("digit1_nibF", bus.bcd_o[7:4], 4'hF);

      // Glitching digit 3 must not complete the frame until it holds still
      for (int d = 0; d < 3; d++) step(sb(d + 4, 1'b0), an_of(d), 10);
      for (int i = 0; i < 10; i++) step(sb(i, 1'b0), an_of(3), 2);
      chk("glitch_noframe", obs_q.size(), 0);
      step(sb(12, 1'b1), an_of(3), STABLE);
      settle(6);
      chk_frames("glitch_then_hold");

      // Non-one-hot strobes are ignored; a partial scan times out
      step(sb(9, 1'b0), 4'b0011, 10);
      step(sb(9, 1'b0), 4'b1111, 10);
      t0 = 0;
      for (int d = 0; d < 3; d++) begin
         step(sb(d + 1, 1'b0), an_of(d), 10);
         if (d == 0) t0 = step_cyc;
      end
      step(sb(8, 1'b0), 4'b0011, 10);
      step(8'hFF, 4'b1111, 1);
      for (int i = 0; i < 200 && n_to == 0; i++) @(posedge clk);
      #1;
      for (int i = 0; i < NDIG; i++) m_have[i] = 1'b0;
      chk("timeout_count", n_to, 1);
      n_tests++;
      assert ((to_cyc >= t0 + TMO + STABLE + 2) && (to_cyc <= t0 + TMO + STABLE + 7)) else begin
         n_fail++;
         $error("FAIL timeout_time: got %0d cycles expected %0d..%0d", to_cyc - t0, TMO + STABLE + 2, TMO + STABLE + 7);
      end
      chk_frames("timeout_noframe");
      chk("timeout_bcd_held", bus.bcd_o, m_last_frame[15:0]);

      // Latest accept of a digit wins
      step(sb(1, 1'b0), an_of(0), 10);
      step(sb(7, 1'b0), an_of(0), 10);
      step(sb(4, 1'b1), an_of(1), 10);
      step(sb(10, 1'b0), an_of(2), 10);
      step(sb(14, 1'b1), an_of(3), 10);
      settle(4);
      chk_frames("overwrite");
      chk("overwrite_nib0", bus.bcd_o[3:0], 4'h7);

      // Reset in the middle of a frame
      step(sb(2, 1'b0), an_of(0), 10);
      step(sb(3, 1'b0), an_of(1), 10);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("midreset");
      bus.sev_seg_i = 8'hFF;
      bus.an_i      = 4'hF;
      m_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      step(sb(6, 1'b1), an_of(0), 10);
      step(sb(11, 1'b0), an_of(1), 10);
      step(sb(13, 1'b0), an_of(2), 10);
      step(sb(15, 1'b0), an_of(3), 10);
      settle(4);
      chk_frames("after_reset");

      // Randomized scans with glitches, bad strobes and re-shown digits
      for (int g = 0; g < 25; g++) begin
         order = '{0, 1, 2, 3};
         for (int i = 3; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
         end
         g_first = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(3, 0) == 0) begin
               case ($urandom_range(2, 0))
                  0: begin s = 8'($urandom); a = an_of($urandom_range(3, 0)); h = $urandom_range(STABLE - 1, 1); end
                  1: begin s = 8'($urandom); a = bad_an[$urandom_range(5, 0)]; h = $urandom_range(8, STABLE); end
                  default: begin s = rand_seg(); a = an_of(order[i]); h = $urandom_range(8, STABLE); end
               endcase
               rstep(s, a, h);
            end
            rstep(rand_seg(), an_of(order[i]), $urandom_range(8, STABLE));
         end
      end
      settle(10);
      chk_frames("random");
      chk("no_extra_timeout", n_to, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
